pulse_scheduler: RTL and testbench
==================================

// Module: pulse_scheduler
// PURPOSE
//  Round-robin scheduler that shares a single delay-then-pulse timer between NCH requesters.
//  Each requester supplies its own run-time delay and pulse width.
//  The winner gets one pulse of the requested width on its own pulse line, followed by a one-cycle ack.
//  Sits between control FSMs and strobe-driven datapath blocks, replacing per-channel one-shot timers.
// PARAMETERS
//  NCH  4  number of requesters (>=2)
//  DW   8  width of each per-channel delay field, in clock cycles
//  WW   4  width of each per-channel pulse-width field, in clock cycles
// PORTS
//  clk        in   1       clock; all logic on the rising edge
//  rst        in   1       synchronous, active-high reset
//  req        in   NCH     level request per channel; hold high until ack
//  delay_cfg  in   NCH*DW  channel i delay at [i*DW +: DW]
//  width_cfg  in   NCH*WW  channel i pulse width at [i*WW +: WW]
//  grant      out  NCH     one-hot: channel currently owning the timer
//  pulse      out  NCH     pulse routed to the granted channel only
//  ack        out  NCH     one-cycle completion strobe to the served channel
//  busy       out  1       high when state != IDLE
// BEHAVIOUR
//  Reset: grant=0, pulse=0, ack=0, busy=0, state=IDLE, RR pointer=0, counters=0.
//  - All outputs are registered. Reset wins over every other event, including mid-DELAY or mid-PULSE.
//  States: IDLE -> DELAY -> PULSE -> IDLE.
//  IDLE, at edge E with |req:
//  - Pick the first requesting channel k, searching from the pointer upward, mod NCH.
//  - Latch k, D = delay_cfg[k], W = width_cfg[k].
//  - Set grant[k]=1 and pointer = (k+1) mod NCH; go to DELAY with the counter cleared.
//  - Ack at edge E: if ack is high at edge E, its channel's req is ignored for arbitration at E.
//    The requester must drop req on the ack cycle or it is served again.
//  Config latching:
//  - D=0 and W=0 are treated as 1.
//  - cfg changes after E have no effect on the running service.
//  DELAY: the counter counts edges.
//  - At edge E+D: pulse[k]=1; go to PULSE with the counter cleared.
//  PULSE: pulse[k] is high for exactly W cycles, between edges E+D and E+D+W.
//  - At edge E+D+W: pulse[k]=0, grant=0, ack[k]=1 for one cycle, state=IDLE.
//  - Next arbitration is at edge E+D+W+1 at the earliest, so there is one idle cycle between services.
//  Abort:
//  - If req[k] is sampled low at any edge while in DELAY: go to IDLE, grant=0.
//  - No pulse and no ack are produced; the pointer stays advanced.
//  - Dropping req[k] during PULSE does not shorten the pulse or suppress the ack.
//  Other rules:
//  - pulse, grant and ack are each at most one-hot, and always on the same channel k.
//  - Counters are DW and WW bits wide; no wrap can occur because D and W fit their fields.
//  - Maximum service time is (2^DW - 1) + (2^WW - 1) + 1 cycles.
// TESTING
//  NCH=4, DW=8, WW=4; E = edge at which req is sampled in IDLE.
//  1 Single: req[1]=1, D=3, W=2
//    -> grant=0010 from E; pulse[1] high across edges E+3..E+4 only;
//       ack[1] for 1 cycle after E+5; busy=0 after E+5.
//  2 Fairness: req=1111 held (each re-raised after its ack), D=1, W=1
//    -> grant order 0,1,2,3,0.
//  3 Simultaneous: pointer=2, req=1001
//    -> ch3 served first, then ch0; pointer=1 after ch0 is granted.
//  4 Zero config: D=0, W=0 on ch2
//    -> pulse[2] high for exactly 1 cycle, starting 1 cycle after E.
//  5 Abort: ch0 D=10; drop req[0] at E+4
//    -> grant=0 after E+4; no pulse, no ack; pending ch1 is granted at E+5.
//  6 Reset: assert rst mid-PULSE on ch3
//    -> all outputs 0 after the next edge; pointer=0; the next req on ch1 is granted normally.

Source files
------------

// File: rtl/pulse_scheduler.sv
// Round-robin scheduler sharing one delay-then-pulse timer between NCH requesters.
// The winner gets a pulse of its own latched width after its own latched delay, then a one-cycle ack.
module pulse_scheduler #(
    parameter int NCH = 4,
    parameter int DW  = 8,
    parameter int WW  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*DW-1:0] delay_cfg,
    input  logic [NCH*WW-1:0] width_cfg,
    output logic [NCH-1:0]    grant,
    output logic [NCH-1:0]    pulse,
    output logic [NCH-1:0]    ack,
    output logic              busy
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, DELAY, PULSE} state_t;

    state_t         state;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  sel;
    logic [DW-1:0]  d_lat;
    logic [WW-1:0]  w_lat;
    logic [DW-1:0]  dcnt;
    logic [WW-1:0]  wcnt;

    logic [NCH-1:0] eligible;
    logic           found;
    logic [PW-1:0]  pick;
    logic [PW-1:0]  idx;
    logic [PW-1:0]  next_ptr;
    logic [DW-1:0]  d_pick;
    logic [WW-1:0]  w_pick;

    // A channel being acked this cycle is excluded so it is not re-served straight away.
    always_comb begin
        eligible = req & ~ack;
        found    = 1'b0;
        pick     = '0;
        idx      = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = PW'((32'(ptr) + i) % NCH);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        d_pick   = '0;
        w_pick   = '0;
        next_ptr = (pick == PW'(NCH - 1)) ? '0 : pick + 1'b1;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (PW'(i) == pick) begin
                d_pick = delay_cfg[i*DW +: DW];
                w_pick = width_cfg[i*WW +: WW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
            d_lat <= '0;
            w_lat <= '0;
            dcnt  <= '0;
            wcnt  <= '0;
            grant <= '0;
            pulse <= '0;
            ack   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (found) begin
                        sel   <= pick;
                        d_lat <= (d_pick == '0) ? DW'(1) : d_pick;
                        w_lat <= (w_pick == '0) ? WW'(1) : w_pick;
                        grant <= NCH'(1) << pick;
                        ptr   <= next_ptr;
                        dcnt  <= '0;
                        busy  <= 1'b1;
                        state <= DELAY;
                    end
                end
                DELAY: begin
                    if (!req[sel]) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (dcnt == d_lat - 1'b1) begin
                        pulse <= grant;
                        wcnt  <= '0;
                        state <= PULSE;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                PULSE: begin
                    if (wcnt == w_lat - 1'b1) begin
                        pulse <= '0;
                        grant <= '0;
                        ack   <= grant;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: begin
                    grant <= '0;
                    pulse <= '0;
                    ack   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler (NCH=4, DW=8, WW=4); outputs sampled 1ns after each rising edge.
module tb_pulse_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] delay_cfg;
    logic [15:0] width_cfg;
    logic [3:0]  grant;
    logic [3:0]  pulse;
    logic [3:0]  ack;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    pulse_scheduler #(.NCH(4), .DW(8), .WW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .delay_cfg (delay_cfg),
        .width_cfg (width_cfg),
        .grant     (grant),
        .pulse     (pulse),
        .ack       (ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_cfg(input int ch, input logic [7:0] d, input logic [3:0] w);
        delay_cfg[ch*8 +: 8] = d;
        width_cfg[ch*4 +: 4] = w;
    endtask

    // Steps until grant is non-zero or the budget runs out; callers compare grant afterwards.
    task automatic wait_grant(input int budget);
        for (int n = 0; n < budget && grant == '0; n++) step();
    endtask

    task automatic wait_ack(input int budget);
        for (int n = 0; n < budget && ack == '0; n++) step();
    endtask

    task automatic test_reset();
        delay_cfg = '0;
        width_cfg = '0;
        do_reset();
        compared++;
        if ({grant, pulse, ack, busy} !== 13'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got grant=%b pulse=%b ack=%b busy=%b, want all 0", grant, pulse, ack, busy);
        end
    endtask

    task automatic test_single();
        logic [3:0] exp_p;
        do_reset();
        set_cfg(1, 8'd3, 4'd2);
        req = 4'b0010;
        step();  // E
        compared++;
        if (grant !== 4'b0010 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL single_grant: got grant=%b busy=%b, want 0010 1", grant, busy);
        end
        for (int n = 1; n <= 5; n++) begin
            step();
            exp_p = (n == 3 || n == 4) ? 4'b0010 : 4'b0000;
            compared++;
            if (pulse !== exp_p) begin
                mismatched++;
                $display("FAIL single_pulse_E+%0d: got %b, want %b", n, pulse, exp_p);
            end
        end
        compared++;
        if (ack !== 4'b0010 || grant !== 4'b0000 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL single_done: got ack=%b grant=%b busy=%b, want 0010 0000 0", ack, grant, busy);
        end
        req = '0;
        step();
        compared++;
        if (ack !== 4'b0000 || grant !== 4'b0000) begin
            mismatched++;
            $display("FAIL single_ack_one_cycle: got ack=%b grant=%b, want 0000 0000", ack, grant);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_g;
        do_reset();
        for (int c = 0; c < 4; c++) set_cfg(c, 8'd1, 4'd1);
        req = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            exp_g = 4'b0001 << (s % 4);
            wait_grant(10);
            compared++;
            if (grant !== exp_g) begin
                mismatched++;
                $display("FAIL fair_grant_%0d: got %b, want %b", s, grant, exp_g);
            end
            wait_ack(10);
            compared++;
            if (ack !== exp_g) begin
                mismatched++;
                $display("FAIL fair_ack_%0d: got %b, want %b", s, ack, exp_g);
            end
        end
        req = '0;
        step();
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int c = 0; c < 4; c++) set_cfg(c, 8'd1, 4'd1);
        req = 4'b0010;  // serve ch1 so the pointer moves to 2
        wait_grant(10);
        wait_ack(10);
        req = 4'b1001;
        step();
        compared++;
        if (grant !== 4'b1000) begin
            mismatched++;
            $display("FAIL simul_first: got grant=%b, want 1000", grant);
        end
        wait_ack(10);
        req = 4'b0001;
        wait_grant(10);
        compared++;
        if (grant !== 4'b0001) begin
            mismatched++;
            $display("FAIL simul_second: got grant=%b, want 0001", grant);
        end
        wait_ack(10);
        // pointer now 1: ch1 must win over ch2
        req = 4'b0110;
        step();
        compared++;
        if (grant !== 4'b0010) begin
            mismatched++;
            $display("FAIL simul_pointer: got grant=%b, want 0010", grant);
        end
        req = '0;
        step();
    endtask

    task automatic test_zero_cfg();
        do_reset();
        set_cfg(2, 8'd0, 4'd0);
        req = 4'b0100;
        step();  // E
        compared++;
        if (grant !== 4'b0100 || pulse !== 4'b0000) begin
            mismatched++;
            $display("FAIL zero_E: got grant=%b pulse=%b, want 0100 0000", grant, pulse);
        end
        step();
        compared++;
        if (pulse !== 4'b0100) begin
            mismatched++;
            $display("FAIL zero_pulse_on: got %b, want 0100", pulse);
        end
        step();
        compared++;
        if (pulse !== 4'b0000 || ack !== 4'b0100) begin
            mismatched++;
            $display("FAIL zero_pulse_off: got pulse=%b ack=%b, want 0000 0100", pulse, ack);
        end
        req = '0;
        step();
    endtask

    task automatic test_abort();
        do_reset();
        set_cfg(0, 8'd10, 4'd1);
        set_cfg(1, 8'd1, 4'd1);
        req = 4'b0011;
        step();  // E
        for (int n = 1; n <= 3; n++) begin
            step();
            compared++;
            if (grant !== 4'b0001 || pulse !== 4'b0000) begin
                mismatched++;
                $display("FAIL abort_hold_E+%0d: got grant=%b pulse=%b, want 0001 0000", n, grant, pulse);
            end
        end
        req = 4'b0010;
        step();  // E+4
        compared++;
        if (grant !== 4'b0000 || pulse !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_drop: got grant=%b pulse=%b ack=%b busy=%b, want 0000 0000 0000 0", grant, pulse, ack, busy);
        end
        step();  // E+5
        compared++;
        if (grant !== 4'b0010 || ack !== 4'b0000) begin
            mismatched++;
            $display("FAIL abort_next: got grant=%b ack=%b, want 0010 0000", grant, ack);
        end
        wait_ack(10);
        req = '0;
        step();
    endtask

    task automatic test_reset_mid_pulse();
        do_reset();
        set_cfg(3, 8'd1, 4'd4);
        set_cfg(1, 8'd1, 4'd1);
        req = 4'b1000;
        step();  // E
        step();
        step();
        compared++;
        if (pulse !== 4'b1000) begin
            mismatched++;
            $display("FAIL rst_pre_pulse: got %b, want 1000", pulse);
        end
        rst = 1'b1;
        step();
        compared++;
        if ({grant, pulse, ack, busy} !== 13'b0) begin
            mismatched++;
            $display("FAIL rst_mid_pulse: got grant=%b pulse=%b ack=%b busy=%b, want all 0", grant, pulse, ack, busy);
        end
        rst = 1'b0;
        req = 4'b0010;
        step();
        compared++;
        if (grant !== 4'b0010) begin
            mismatched++;
            $display("FAIL rst_then_grant: got %b, want 0010", grant);
        end
        wait_ack(10);
        compared++;
        if (ack !== 4'b0010) begin
            mismatched++;
            $display("FAIL rst_then_ack: got %b, want 0010", ack);
        end
        req = '0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        delay_cfg = '0;
        width_cfg = '0;
        test_reset();
        test_single();
        test_fairness();
        test_simultaneous();
        test_zero_cfg();
        test_abort();
        test_reset_mid_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
